tri_seq_ctrl: RTL and testbench
===============================

TRI_SEQ_CTRL -- requirements
Module: tri_seq_ctrl

Interface
REQ-001 Parameters: DW, default 9, width of d_out and peak. HW, default 8, width of hold count. NPROF, default 4, number of profile slots (fixed power of two).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 res  in  1  reset; synchronous and active-high.
REQ-004 cfg_we  in  1  profile write strobe, one cycle per write.
REQ-005 cfg_addr  in  2  profile slot to write.
REQ-006 cfg_peak  in  DW  peak value for the slot.
REQ-007 cfg_hold  in  HW  hold count for the slot (flat-top and flat-bottom length).
REQ-008 start  in  1  single-cycle request to begin a sequence.
REQ-009 stop  in  1  single-cycle request to end the sequence gracefully.
REQ-010 rep  in  4  number of passes through all slots, sampled on accepted start; 0 means run until stopped.
REQ-011 d_out  out  DW  triangle waveform sample, registered.
REQ-012 busy  out  1  high from the cycle after an accepted start until the cycle done is asserted (inclusive).
REQ-013 done  out  1  one-cycle pulse on the last BOT cycle of the sequence.
REQ-014 prof_idx  out  2  slot currently playing.

Function
REQ-015 FSM states: IDLE, RISE, TOP, FALL, BOT.
REQ-016 start in IDLE is accepted: rep is latched, prof_idx=0, slot 0 is latched into active peak/hold, and the FSM goes to RISE with d_out=0.
REQ-017 start outside IDLE is ignored.
REQ-018 RISE: if d_out==peak, go to TOP; otherwise d_out+1. Duration is peak+1 cycles; peak=0 is legal (1 cycle).
REQ-019 TOP: counter con increments from 0; on con==hold, go to FALL and clear con. Duration is hold+1 cycles; d_out is held.
REQ-020 FALL: if d_out==0, go to BOT; otherwise d_out-1. Duration is peak+1 cycles.
REQ-021 BOT: same counting rule as TOP, with d_out=0. Period per slot is 2*peak+2*hold+4 cycles.
REQ-022 At BOT end: prof_idx increments, wrapping NPROF-1 to 0. The next slot is latched and the FSM goes to RISE.
REQ-023 On wrap, the pass counter increments. When pass count reaches rep (rep!=0), done pulses and the FSM goes to IDLE instead.
REQ-024 stop while not IDLE sets stop_pend. At the end of the current BOT, done pulses, the FSM goes to IDLE and stop_pend clears. The waveform is never truncated.
REQ-025 stop in IDLE has no effect. start and stop together in IDLE: start accepted, stop ignored.
REQ-026 cfg_we is accepted in any state and updates the table only. A playing slot keeps its latched values; new values take effect on the next latch of that slot.
REQ-027 cfg_we to a slot in the same cycle that slot is latched: the old value is latched.
REQ-028 cfg_peak is an unsigned value up to 2^DW-1. No arithmetic overflow is possible, because the compare precedes the increment.

Reset
REQ-029 res high: state=IDLE, d_out=0, con=0, prof_idx=0, busy=0, done=0, stop_pend=0, pass count=0.
REQ-030 res high: every table slot resets to peak=299, hold=200.
REQ-031 res mid-sequence aborts immediately with no done pulse. Outputs show reset values on the cycle after the res edge.

Structure
REQ-032 A shared package holds the FSM state enum, NPROF, and the reset constants RST_PEAK=299 and RST_HOLD=200.
REQ-033 Sub-module tri_core: a loadable up/down counter with hold counter, driven by the controller with load, dir and hold-enable controls.
REQ-034 Top level holds the profile table, pass counter, stop logic and FSM.

Verification
REQ-035 Reset, start with rep=1, default table -> 4 slots x 1002 cycles; done pulses once at cycle 4008 after start; d_out peaks at 299.
REQ-036 Slot 1 = (peak 0, hold 0), rep=1 -> slot 1 lasts 4 cycles, with d_out 0,0,0,0.
REQ-037 rep=0, stop asserted mid-RISE of slot 2 -> slot 2 completes; done pulses at its BOT end; prof_idx=2 at done.
REQ-038 Write slot 0 peak=10 while slot 0 is playing -> current pass is unchanged; the second pass peaks at 10.
REQ-039 start and stop in the same IDLE cycle -> sequence starts; busy=1 next cycle.
REQ-040 res asserted during TOP -> next cycle d_out=0, busy=0; done never asserts.

Source files
------------

// File: rtl/tri_seq_ctrl_pkg.sv
// Shared types and constants for the triangle sequence controller.
package tri_seq_ctrl_pkg;

  localparam int unsigned NPROF    = 4;
  localparam int unsigned RST_PEAK = 299;
  localparam int unsigned RST_HOLD = 200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RISE,
    ST_TOP,
    ST_FALL,
    ST_BOT
  } state_e;

endpackage

// File: rtl/tri_core.sv
// Loadable up/down sample counter plus a plateau (hold) counter.
module tri_core #(
  parameter int unsigned DW = 9,
  parameter int unsigned HW = 8
) (
  input  logic          clk,
  input  logic          res,
  input  logic          load,
  input  logic          step_en,
  input  logic          dir,
  input  logic          hold_en,
  input  logic          hold_clr,
  output logic [DW-1:0] cnt,
  output logic [HW-1:0] con
);

  logic [DW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] con_q, con_d;

  // load wins over stepping so a new sequence always starts from zero
  always_comb begin
    cnt_d = cnt_q;
    con_d = con_q;
    if (load) begin
      cnt_d = '0;
      con_d = '0;
    end else begin
      if (step_en) cnt_d = dir ? cnt_q + DW'(1) : cnt_q - DW'(1);
      if (hold_clr)     con_d = '0;
      else if (hold_en) con_d = con_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= '0;
      con_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      con_q <= con_d;
    end
  end

  assign cnt = cnt_q;
  assign con = con_q;

endmodule

// File: rtl/tri_seq_ctrl.sv
// Triangle waveform sequencer: plays a table of peak/hold profiles for a
// programmable number of passes, with graceful stop at the end of a slot.
module tri_seq_ctrl #(
  parameter int unsigned DW    = 9,
  parameter int unsigned HW    = 8,
  parameter int unsigned NPROF = tri_seq_ctrl_pkg::NPROF
) (
  input  logic          clk,
  input  logic          res,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [DW-1:0] cfg_peak,
  input  logic [HW-1:0] cfg_hold,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    rep,
  output logic [DW-1:0] d_out,
  output logic          busy,
  output logic          done,
  output logic [1:0]    prof_idx
);

  import tri_seq_ctrl_pkg::*;

  localparam int unsigned PW = 2;
  localparam logic [PW-1:0] LAST_SLOT = PW'(NPROF - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] peak_tbl_q [NPROF];
  logic [DW-1:0] peak_tbl_d [NPROF];
  logic [HW-1:0] hold_tbl_q [NPROF];
  logic [HW-1:0] hold_tbl_d [NPROF];
  logic [DW-1:0] peak_act_q, peak_act_d;
  logic [HW-1:0] hold_act_q, hold_act_d;
  logic [3:0]    rep_q, rep_d;
  logic [3:0]    pass_q, pass_d;
  logic [PW-1:0] prof_q, prof_d;
  logic          stop_pend_q, stop_pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          core_load, core_step, core_dir, core_hold_en, core_hold_clr;
  logic [DW-1:0] cnt;
  logic [HW-1:0] con;
  logic [PW-1:0] next_prof;
  logic          last_pass;
  logic          hold_nxt;
  logic          seq_end;

  tri_core #(
    .DW (DW),
    .HW (HW)
  ) u_core (
    .clk      (clk),
    .res      (res),
    .load     (core_load),
    .step_en  (core_step),
    .dir      (core_dir),
    .hold_en  (core_hold_en),
    .hold_clr (core_hold_clr),
    .cnt      (cnt),
    .con      (con)
  );

  assign next_prof = (prof_q == LAST_SLOT) ? '0 : prof_q + PW'(1);
  assign last_pass = (rep_q != '0) && (prof_q == LAST_SLOT) &&
                     (({1'b0, pass_q} + 5'd1) == {1'b0, rep_q});
  assign hold_nxt  = (({1'b0, con} + (HW+1)'(1)) == {1'b0, hold_act_q});

  // Table writes land after this edge's latch, so a same-cycle latch sees old data
  always_comb begin
    for (int unsigned i = 0; i < NPROF; i++) begin
      peak_tbl_d[i] = peak_tbl_q[i];
      hold_tbl_d[i] = hold_tbl_q[i];
    end
    if (cfg_we) begin
      peak_tbl_d[cfg_addr] = cfg_peak;
      hold_tbl_d[cfg_addr] = cfg_hold;
    end
  end

  // done is registered, so the ending decision is made one cycle ahead of the last BOT cycle
  always_comb begin
    state_d       = state_q;
    prof_d        = prof_q;
    pass_d        = pass_q;
    rep_d         = rep_q;
    peak_act_d    = peak_act_q;
    hold_act_d    = hold_act_q;
    stop_pend_d   = stop_pend_q | (stop & (state_q != ST_IDLE));
    done_d        = 1'b0;
    core_load     = 1'b0;
    core_step     = 1'b0;
    core_dir      = 1'b0;
    core_hold_en  = 1'b0;
    core_hold_clr = 1'b0;
    seq_end       = stop_pend_d | last_pass;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rep_d       = rep;
          pass_d      = '0;
          prof_d      = '0;
          peak_act_d  = peak_tbl_q[0];
          hold_act_d  = hold_tbl_q[0];
          stop_pend_d = 1'b0;
          core_load   = 1'b1;
          state_d     = ST_RISE;
        end
      end
      ST_RISE: begin
        if (cnt == peak_act_q) begin
          state_d = ST_TOP;
        end else begin
          core_step = 1'b1;
          core_dir  = 1'b1;
        end
      end
      ST_TOP: begin
        if (con == hold_act_q) begin
          core_hold_clr = 1'b1;
          state_d       = ST_FALL;
        end else begin
          core_hold_en = 1'b1;
        end
      end
      ST_FALL: begin
        if (cnt == '0) begin
          state_d = ST_BOT;
          done_d  = seq_end & (hold_act_q == '0);
        end else begin
          core_step = 1'b1;
        end
      end
      ST_BOT: begin
        if (con == hold_act_q) begin
          core_hold_clr = 1'b1;
          if (done_q) begin
            stop_pend_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            prof_d     = next_prof;
            peak_act_d = peak_tbl_q[next_prof];
            hold_act_d = hold_tbl_q[next_prof];
            if (prof_q == LAST_SLOT) pass_d = pass_q + 4'd1;
            state_d = ST_RISE;
          end
        end else begin
          core_hold_en = 1'b1;
          done_d       = seq_end & hold_nxt;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      peak_act_q  <= '0;
      hold_act_q  <= '0;
      rep_q       <= '0;
      pass_q      <= '0;
      prof_q      <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < NPROF; i++) begin
        peak_tbl_q[i] <= DW'(RST_PEAK);
        hold_tbl_q[i] <= HW'(RST_HOLD);
      end
    end else begin
      state_q     <= state_d;
      peak_act_q  <= peak_act_d;
      hold_act_q  <= hold_act_d;
      rep_q       <= rep_d;
      pass_q      <= pass_d;
      prof_q      <= prof_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int unsigned i = 0; i < NPROF; i++) begin
        peak_tbl_q[i] <= peak_tbl_d[i];
        hold_tbl_q[i] <= hold_tbl_d[i];
      end
    end
  end

  assign d_out    = cnt;
  assign busy     = busy_q;
  assign done     = done_q;
  assign prof_idx = prof_q;

endmodule

// File: tb/tb_tri_seq_ctrl.sv
// Bench for tri_seq_ctrl: per-cycle comparison against a slot-position model
// plus directed scenarios with hand-computed expectations.
module tb_tri_seq_ctrl;

  logic       clk = 1'b0;
  logic       res, cfg_we, start, stop;
  logic [1:0] cfg_addr;
  logic [8:0] cfg_peak;
  logic [7:0] cfg_hold;
  logic [3:0] rep;
  logic [8:0] d_out;
  logic       busy, done;
  logic [1:0] prof_idx;

  tri_seq_ctrl #(.DW(9), .HW(8), .NPROF(4)) dut (
    .clk(clk), .res(res), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_peak(cfg_peak), .cfg_hold(cfg_hold), .start(start), .stop(stop),
    .rep(rep), .d_out(d_out), .busy(busy), .done(done), .prof_idx(prof_idx)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: position k within the current slot determines the sample directly
  int m_pk [4];
  int m_hd [4];
  int m_p, m_h, m_k, m_slot, m_pass, m_rep;
  bit m_act, m_stop, m_fin;
  int exp_d, exp_idx;
  bit exp_busy, exp_done;

  function automatic int wave(input int k, input int p, input int h);
    if (k <= p)             return k;
    if (k <= p + h + 1)     return p;
    if (k <= 2 * p + h + 2) return p - (k - (p + h + 2));
    return 0;
  endfunction

  always @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < 4; i++) begin m_pk[i] = 299; m_hd[i] = 200; end
      m_act = 0; m_stop = 0; m_fin = 0; m_k = 0; m_slot = 0; m_pass = 0;
      m_rep = 0; m_p = 0; m_h = 0;
    end else begin
      if (!m_act) begin
        if (start) begin
          m_act = 1; m_rep = int'(rep); m_slot = 0; m_pass = 0; m_k = 0;
          m_p = m_pk[0]; m_h = m_hd[0]; m_stop = 0;
        end
        m_fin = 0;
      end else begin
        if (stop) m_stop = 1;
        m_k++;
        if (m_k == 2 * m_p + 2 * m_h + 4) begin
          if (m_fin) begin
            m_act = 0; m_stop = 0;
          end else begin
            m_k = 0;
            if (m_slot == 3) begin m_slot = 0; m_pass++; end
            else m_slot++;
            m_p = m_pk[m_slot]; m_h = m_hd[m_slot];
          end
        end
        m_fin = m_act && (m_k == 2 * m_p + 2 * m_h + 3) &&
                (m_stop || (m_rep != 0 && m_slot == 3 && m_pass + 1 == m_rep));
      end
      if (cfg_we) begin
        m_pk[cfg_addr] = int'(cfg_peak);
        m_hd[cfg_addr] = int'(cfg_hold);
      end
    end
    exp_busy = m_act;
    exp_d    = m_act ? wave(m_k, m_p, m_h) : 0;
    exp_idx  = m_slot;
    exp_done = m_fin;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_assert++;
      if (int'(d_out) != exp_d || busy != exp_busy || done != exp_done ||
          int'(prof_idx) != exp_idx) begin
        n_fail++;
        $display("FAIL model t=%0t: d_out=%0d want %0d busy=%b want %b done=%b want %b idx=%0d want %0d",
                 $time, d_out, exp_d, busy, exp_busy, done, exp_done, prof_idx, exp_idx);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Scenario observations
  int mx [4][4];
  int ncyc [4];
  int or1, n_done, done_cyc, done_idx;

  task automatic do_reset();
    res = 1'b1; cyc(); cyc(); res = 1'b0;
  endtask

  task automatic start_seq(input int r);
    rep = 4'(r); start = 1'b1; cyc(); start = 1'b0;
  endtask

  // Runs until busy drops; optional one-shot stop and one-shot slot-0 rewrite
  task automatic watch(input int stop_slot, input int stop_at, input int wr_at, input int limit);
    int c, pass, prev;
    bit stopped;
    c = 1; pass = 0; prev = 0; stopped = 0;
    for (int i = 0; i < 4; i++) begin
      ncyc[i] = 0;
      for (int j = 0; j < 4; j++) mx[i][j] = -1;
    end
    or1 = 0; n_done = 0; done_cyc = -1; done_idx = -1;
    while (busy && c < limit) begin
      if (prof_idx == 2'd0 && prev == 3) pass++;
      prev = int'(prof_idx);
      if (pass < 4 && int'(d_out) > mx[pass][prof_idx]) mx[pass][prof_idx] = int'(d_out);
      if (pass == 0) ncyc[prof_idx]++;
      if (pass == 0 && prof_idx == 2'd1) or1 = or1 | int'(d_out);
      if (done) begin n_done++; done_cyc = c; done_idx = int'(prof_idx); end
      stop = 1'b0;
      if (!stopped && stop_slot >= 0 && int'(prof_idx) == stop_slot && int'(d_out) == stop_at) begin
        stop = 1'b1; stopped = 1;
      end
      cfg_we = 1'b0;
      if (c == wr_at) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_peak = 9'd10; cfg_hold = 8'd200;
      end
      cyc(); c++;
    end
    stop = 1'b0; cfg_we = 1'b0;
    chk("busy_drops_in_budget", int'(busy), 0);
  endtask

  initial begin
    int nd;
    res = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_peak = '0; cfg_hold = '0;
    start = 1'b0; stop = 1'b0; rep = '0;
    cyc(); chk_en = 1'b1; cyc(); res = 1'b0; cyc();
    chk("rst_d_out", int'(d_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(prof_idx), 0);

    // Default table, one pass
    start_seq(1);
    chk("s1_first_d", int'(d_out), 0);
    chk("s1_first_busy", int'(busy), 1);
    watch(-1, 0, -1, 10000);
    chk("s1_done_count", n_done, 1);
    chk("s1_done_cycle", done_cyc, 4008);
    chk("s1_slot0_len", ncyc[0], 1002);
    chk("s1_peak_slot0", mx[0][0], 299);
    chk("s1_peak_slot3", mx[0][3], 299);
    chk("s1_done_idx", done_idx, 3);

    // Degenerate slot 1: peak 0, hold 0
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_peak = 9'd0; cfg_hold = 8'd0; cyc(); cfg_we = 1'b0;
    start_seq(1);
    watch(-1, 0, -1, 10000);
    chk("s2_slot1_len", ncyc[1], 4);
    chk("s2_slot1_all_zero", or1, 0);
    chk("s2_done_cycle", done_cyc, 3010);

    // Free-running with graceful stop in slot 2 rise
    do_reset();
    start_seq(0);
    watch(2, 50, -1, 20000);
    chk("s3_done_count", n_done, 1);
    chk("s3_done_cycle", done_cyc, 3006);
    chk("s3_done_idx", done_idx, 2);

    // Rewrite slot 0 while it plays; only pass 2 sees it
    do_reset();
    start_seq(2);
    watch(-1, 0, 5, 20000);
    chk("s4_pass1_peak", mx[0][0], 299);
    chk("s4_pass2_peak", mx[1][0], 10);
    chk("s4_done_cycle", done_cyc, 7438);
    chk("s4_done_count", n_done, 1);

    // start+stop together, then reset during TOP
    do_reset();
    rep = 4'd1; start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("s5_busy_after_start", int'(busy), 1);
    repeat (309) cyc();
    chk("s5_in_top_d", int'(d_out), 299);
    res = 1'b1; cyc(); res = 1'b0;
    chk("s5_rst_d", int'(d_out), 0);
    chk("s5_rst_busy", int'(busy), 0);
    chk("s5_rst_done", int'(done), 0);
    nd = 0;
    repeat (20) begin cyc(); if (done) nd++; end
    chk("s5_no_done", nd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
